axi4_frame_writer: RTL and testbench

//  AXI4 write master that pushes one frame of pixel groups, as fixed-length INCR bursts, into an AXI4 write slave
//  (the frame fetch ingress). Pixel groups arrive on a valid/ready stream from the capture/DMA side.
//  One burst is outstanding at a time: AW, then W beats, then B; repeated until the frame is complete.

---
 rtl/axi4_frame_writer.sv | 142 ++++++++++++++
 tb/tb_axi4_frame_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_writer.sv
// AXI4 write master: streams one frame of pixel groups into memory as back-to-back
// fixed-length INCR bursts, with a single burst (AW, W beats, B) in flight at a time.
module axi4_frame_writer #(
    parameter int MST_ID_W         = 3,
    parameter int MST_ID           = 0,
    parameter int DATA_WIDTH       = 256,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3,
    parameter int BURST_LEN        = 8,
    parameter int FRAME_BEAT_NUM   = 3600
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start_i,
    input  logic [ADDR_WIDTH-1:0]       base_addr_i,
    input  logic [DATA_WIDTH-1:0]       pg_data_i,
    input  logic                        pg_valid_i,
    output logic                        pg_ready_o,
    output logic [MST_ID_W-1:0]         m_AWID_o,
    output logic [ADDR_WIDTH-1:0]       m_AWADDR_o,
    output logic [TRANS_DATA_LEN_W-1:0] m_AWLEN_o,
    output logic [2:0]                  m_AWSIZE_o,
    output logic [1:0]                  m_AWBURST_o,
    output logic                        m_AWVALID_o,
    input  logic                        m_AWREADY_i,
    output logic [DATA_WIDTH-1:0]       m_WDATA_o,
    output logic                        m_WLAST_o,
    output logic                        m_WVALID_o,
    input  logic                        m_WREADY_i,
    input  logic [MST_ID_W-1:0]         m_BID_i,
    input  logic [1:0]                  m_BRESP_i,
    input  logic                        m_BVALID_i,
    output logic                        m_BREADY_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        resp_err_o
);

    localparam int BURST_NUM   = FRAME_BEAT_NUM / BURST_LEN;
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W     = (BURST_NUM > 1) ? $clog2(BURST_NUM) : 1;
    localparam int BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);

    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]    LAST_BURST  = BURST_W'(BURST_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [MST_ID_W-1:0]   OWN_ID      = MST_ID_W'(MST_ID);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 in_data;
    logic                 w_fire;
    logic                 bad_resp;

    assign m_AWID_o    = OWN_ID;
    assign m_AWLEN_o   = TRANS_DATA_LEN_W'(BURST_LEN - 1);
    assign m_AWSIZE_o  = 3'($clog2(DATA_WIDTH / 8));
    assign m_AWBURST_o = 2'b01;

    // The W channel is a direct pass-through of the pixel stream, gated so that
    // nothing moves unless the current burst's address has already been accepted.
    assign in_data    = (state == DATA);
    assign m_WDATA_o  = pg_data_i;
    assign m_WVALID_o = in_data & pg_valid_i;
    assign pg_ready_o = in_data & m_WREADY_i;
    assign m_WLAST_o  = in_data & (beat_cnt == LAST_BEAT);
    assign w_fire     = in_data & pg_valid_i & m_WREADY_i;
    assign bad_resp   = (m_BRESP_i != 2'b00) | (m_BID_i != OWN_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            m_AWVALID_o  <= 1'b0;
            m_AWADDR_o   <= '0;
            m_BREADY_o   <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            resp_err_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        m_AWADDR_o  <= base_addr_i;
                        burst_cnt   <= '0;
                        resp_err_o  <= 1'b0;
                        m_AWVALID_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_AWREADY_i) begin
                        m_AWVALID_o <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            m_BREADY_o <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (m_BVALID_i) begin
                        m_BREADY_o <= 1'b0;
                        burst_cnt  <= burst_cnt + 1'b1;
                        if (bad_resp) begin
                            resp_err_o <= 1'b1;
                        end
                        // Address advances by whole bursts and wraps at the top of the space.
                        if (burst_cnt == LAST_BURST) begin
                            busy_o       <= 1'b0;
                            frame_done_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            m_AWADDR_o  <= m_AWADDR_o + ADDR_STEP;
                            m_AWVALID_o <= 1'b1;
                            state       <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Scoreboard bench for axi4_frame_writer: a stream source and AXI slave model feed
// expectation queues that a negedge monitor pops and compares on every handshake.
module tb_axi4_frame_writer;

    localparam int DW  = 256;
    localparam int AW  = 32;
    localparam int IDW = 3;
    localparam int LW  = 3;
    localparam int BL  = 8;
    localparam int FBN = 3600;
    localparam int NB  = FBN / BL;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start_i;
    logic [AW-1:0] base_addr_i;
    logic [DW-1:0] pg_data_i;
    logic          pg_valid_i;
    logic          pg_ready_o;
    logic [IDW-1:0] m_AWID_o;
    logic [AW-1:0] m_AWADDR_o;
    logic [LW-1:0] m_AWLEN_o;
    logic [2:0]    m_AWSIZE_o;
    logic [1:0]    m_AWBURST_o;
    logic          m_AWVALID_o;
    logic          m_AWREADY_i;
    logic [DW-1:0] m_WDATA_o;
    logic          m_WLAST_o;
    logic          m_WVALID_o;
    logic          m_WREADY_i;
    logic [IDW-1:0] m_BID_i;
    logic [1:0]    m_BRESP_i;
    logic          m_BVALID_i;
    logic          m_BREADY_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          resp_err_o;

    always #5 clk = ~clk;

    axi4_frame_writer #(
        .MST_ID_W(IDW), .MST_ID(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TRANS_DATA_LEN_W(LW), .BURST_LEN(BL), .FRAME_BEAT_NUM(FBN)
    ) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start_i), .base_addr_i(base_addr_i),
        .pg_data_i(pg_data_i), .pg_valid_i(pg_valid_i), .pg_ready_o(pg_ready_o),
        .m_AWID_o(m_AWID_o), .m_AWADDR_o(m_AWADDR_o), .m_AWLEN_o(m_AWLEN_o),
        .m_AWSIZE_o(m_AWSIZE_o), .m_AWBURST_o(m_AWBURST_o), .m_AWVALID_o(m_AWVALID_o),
        .m_AWREADY_i(m_AWREADY_i), .m_WDATA_o(m_WDATA_o), .m_WLAST_o(m_WLAST_o),
        .m_WVALID_o(m_WVALID_o), .m_WREADY_i(m_WREADY_i), .m_BID_i(m_BID_i),
        .m_BRESP_i(m_BRESP_i), .m_BVALID_i(m_BVALID_i), .m_BREADY_o(m_BREADY_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .resp_err_o(resp_err_o)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    bit rnd = 1'b0;
    int err_burst = -1;
    int frame_aw = 0, frame_w = 0, frame_b = 0, done_cnt = 0, open_bursts = 0;
    int pend_b = 0, seq = 0;
    bit exp_err = 1'b0;
    bit aw_hs, w_hs, wl_hs, b_hs, pg_hs, prev_aw_stall, prev_done;
    logic [AW-1:0] prev_awaddr;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Monitor: handshakes seen here take effect at the coming posedge.
    always @(negedge clk) begin
        int open0;
        aw_hs = 1'b0; w_hs = 1'b0; wl_hs = 1'b0; b_hs = 1'b0; pg_hs = 1'b0;
        if (rst) begin
            exp_err = 1'b0; frame_aw = 0; frame_w = 0; frame_b = 0; open_bursts = 0;
            prev_aw_stall = 1'b0; prev_done = 1'b0;
        end else begin
            open0 = open_bursts;
            check("resp_err", resp_err_o, exp_err);
            if (prev_aw_stall) begin
                check("awvalid_hold", m_AWVALID_o, 1);
                check("awaddr_hold", m_AWADDR_o, prev_awaddr);
            end
            aw_hs = m_AWVALID_o & m_AWREADY_i;
            w_hs  = m_WVALID_o & m_WREADY_i;
            wl_hs = w_hs & m_WLAST_o;
            b_hs  = m_BVALID_i & m_BREADY_o;
            pg_hs = pg_valid_i & pg_ready_o;
            if (w_hs) begin
                check("w_after_aw", open0, 1);
                check("pg_accept", pg_hs, 1);
                if (w_q.size() == 0) check("w_unexpected", 1, 0);
                else check("wdata", m_WDATA_o, w_q.pop_front());
                check("wlast", m_WLAST_o, (frame_w % BL) == BL - 1);
                frame_w++;
            end else if (pg_hs) begin
                check("pg_without_w", 1, 0);
            end
            if (aw_hs) begin
                check("aw_one_outstanding", open0, 0);
                if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else check("awaddr", m_AWADDR_o, aw_q.pop_front());
                check("aw_attr", {m_AWID_o, m_AWLEN_o, m_AWSIZE_o, m_AWBURST_o},
                      {3'd0, 3'd7, 3'd5, 2'b01});
                open_bursts++;
                frame_aw++;
            end
            if (b_hs) begin
                check("b_outstanding", open0, 1);
                open_bursts--;
                frame_b++;
                if (m_BRESP_i != 2'b00) exp_err = 1'b1;
            end
            if (frame_done_o) begin
                done_cnt++;
                check("done_after_last_b", frame_b, NB);
                check("done_pulse", prev_done, 0);
            end
            if (frame_start_i && !busy_o) begin
                exp_err = 1'b0; frame_aw = 0; frame_w = 0; frame_b = 0;
            end
            prev_done     = frame_done_o;
            prev_aw_stall = m_AWVALID_o & ~m_AWREADY_i;
            prev_awaddr   = m_AWADDR_o;
        end
    end

    // Pixel source and AXI slave model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pg_valid_i = 1'b0; m_AWREADY_i = 1'b0; m_WREADY_i = 1'b0; m_BVALID_i = 1'b0;
                pend_b = 0;
                aw_q.delete();
                w_q.delete();
            end else begin
                if (pg_hs) pg_valid_i = 1'b0;
                if (!pg_valid_i && (!rnd || $urandom_range(0, 3) != 0)) begin
                    seq++;
                    for (int k = 0; k < 8; k++) pg_data_i[k*32 +: 32] = 32'(seq * 8 + k) ^ 32'hC3A5_0000;
                    pg_valid_i = 1'b1;
                    w_q.push_back(pg_data_i);
                end
                m_AWREADY_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_WREADY_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (wl_hs) pend_b++;
                if (b_hs) m_BVALID_i = 1'b0;
                if (!m_BVALID_i && pend_b > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                    m_BVALID_i = 1'b1;
                    m_BRESP_i  = (frame_b == err_burst) ? 2'b10 : 2'b00;
                    pend_b--;
                end
            end
        end
    end

    task automatic start_frame(input logic [AW-1:0] base, input bit accept);
        @(posedge clk);
        #1;
        frame_start_i = 1'b1;
        base_addr_i   = base;
        if (accept) begin
            for (int i = 0; i < NB; i++) aw_q.push_back(base + AW'(i * 256));
        end
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done timeout, got %0d bursts, expected %0d", name, frame_aw, NB);
            finish_sim();
        end
        check({name, "_aw_count"}, frame_aw, NB);
        check({name, "_w_count"}, frame_w, FBN);
        check({name, "_b_count"}, frame_b, NB);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_handshake_outs"}, {m_AWVALID_o, m_WVALID_o, m_WLAST_o, pg_ready_o, m_BREADY_o}, 0);
        check({name, "_status"}, {busy_o, frame_done_o, resp_err_o}, 0);
        check({name, "_awaddr"}, m_AWADDR_o, 0);
    endtask

    initial begin
        rst = 1'b1; frame_start_i = 1'b0; base_addr_i = '0; pg_data_i = '0; pg_valid_i = 1'b0;
        m_AWREADY_i = 1'b0; m_WREADY_i = 1'b0; m_BID_i = '0; m_BRESP_i = 2'b00; m_BVALID_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame with an always-ready slave and always-valid stream.
        start_frame(32'h1000_0000, 1'b1);
        wait_done("t1");

        // Random handshake delays and stream gaps.
        rnd = 1'b1;
        start_frame(32'h2000_0000, 1'b1);
        wait_done("t2");
        rnd = 1'b0;

        // SLVERR on burst 5 must stick to frame end without aborting.
        err_burst = 5;
        start_frame(32'h3000_0000, 1'b1);
        wait_done("t3");
        check("t3_err_sticky", resp_err_o, 1);
        err_burst = -1;

        // Mid-frame start is ignored; start right after frame_done is accepted.
        start_frame(32'h4000_0000, 1'b1);
        repeat (200) @(posedge clk);
        start_frame(32'h5555_0000, 1'b0);
        wait_done("t4a");
        start_frame(32'h6000_0000, 1'b1);
        wait_done("t4b");

        // Reset during beat 3 of burst 10, then a clean frame from burst 0.
        start_frame(32'h7000_0000, 1'b1);
        for (int i = 0; i < 5000 && frame_w < 10 * BL + 3; i++) @(posedge clk);
        #1;
        check("t5_reached_burst10", frame_w, 10 * BL + 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t5_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_frame(32'h7100_0000, 1'b1);
        wait_done("t5");

        // Address wraps past the top of the space.
        start_frame(32'hFFFF_FF00, 1'b1);
        wait_done("t6");

        repeat (5) @(negedge clk);
        check("done_pulses", done_cnt, 7);
        check("aw_queue_drained", aw_q.size(), 0);
        finish_sim();
    end

endmodule
